// File: rtl/sixteen_bit_adder.sv
// sixteen_bit_adder: 16-bit two-level carry-lookahead adder with registered
// result and flags (one clock of latency, one operation per cycle).
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset, clears all output registers
//   in_valid  operands valid; captured on the rising edge
//   A, B      16-bit operands
//   Cin       carry-in (chain from a lower 16-bit slice for 32-bit adds)
//   Sum       registered (A + B + Cin) mod 65536
//   Cout      registered carry out of bit 15
//   Ovf       registered signed overflow (c16 ^ c15)
//   out_valid registered copy of in_valid
//
// Sum/Cout/Ovf hold their last captured values while in_valid is low.
// out_valid marks them as fresh for exactly one cycle.

// 4-bit lookahead group: internal carries from the group carry-in,
// plus group generate/propagate for the second-level unit.
module cla4_group (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,    // carry into each bit of the group
  output logic       gg,
  output logic       gp
);
  // Every carry is a flat sum of products of g/p/cin: no ripple inside the group.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;
endmodule

// Second-level lookahead: group carry-ins c0/c4/c8/c12 and the final c16,
// each derived directly from GG/GP and Cin.
module cla_lcu4 (
  input  logic [3:0] gg,
  input  logic [3:0] gp,
  input  logic       cin,
  output logic [3:0] gc,   // carry into each group (c0, c4, c8, c12)
  output logic       cout  // c16
);
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
endmodule

module sixteen_bit_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        Ovf,
  output logic        out_valid
);
  localparam int NUM_GRP = 4;
  localparam int GRP_W   = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } add_rsp_t;

  logic [NUM_GRP-1:0][GRP_W-1:0] g, p, c;
  logic [NUM_GRP-1:0]            gg, gp, gc;
  logic                          c16;
  add_rsp_t                      rsp_d, rsp_q;

  assign g = A & B;
  assign p = A ^ B;

  genvar i;
  generate
    for (i = 0; i < NUM_GRP; i++) begin : g_grp
      cla4_group u_grp (
        .g   (g[i]),
        .p   (p[i]),
        .cin (gc[i]),
        .c   (c[i]),
        .gg  (gg[i]),
        .gp  (gp[i])
      );
    end
  endgenerate

  cla_lcu4 u_lcu (
    .gg   (gg),
    .gp   (gp),
    .cin  (Cin),
    .gc   (gc),
    .cout (c16)
  );

  assign rsp_d.sum  = p ^ c;
  assign rsp_d.cout = c16;
  // c[3][3] is the carry into bit 15; overflow when it differs from c16.
  assign rsp_d.ovf  = c16 ^ c[3][3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) rsp_q <= rsp_d;
    end
  end

  assign Sum  = rsp_q.sum;
  assign Cout = rsp_q.cout;
  assign Ovf  = rsp_q.ovf;
endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Self-checking bench for sixteen_bit_adder: directed vectors with constant
// expectations, then a random sweep against a plain-arithmetic model.
module tb_sixteen_bit_adder;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A, B;
  logic        Cin;
  logic [15:0] Sum;
  logic        Cout, Ovf, out_valid;

  int checks = 0;
  int errors = 0;

  // model state: last captured result and freshness
  logic [15:0] m_sum;
  logic        m_cout, m_ovf, m_vld;

  sixteen_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sum"},   Sum,       m_sum);
    chk({tag, ".cout"},  Cout,      m_cout);
    chk({tag, ".ovf"},   Ovf,       m_ovf);
    chk({tag, ".valid"}, out_valid, m_vld);
  endtask

  // Drive one cycle, update the model, sample 1 time unit after the edge.
  task automatic step(input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic v, input string tag);
    logic [16:0] full;
    A = a; B = b; Cin = ci; in_valid = v;
    @(posedge clk); #1;
    if (v) begin
      full   = 17'(a) + 17'(b) + 17'(ci);
      m_sum  = full[15:0];
      m_cout = full[16];
      m_ovf  = (a[15] == b[15]) && (m_sum[15] != a[15]);
    end
    m_vld = v;
    chk_all(tag);
  endtask

  // directed table: a, b, cin, expected sum, cout, ovf
  typedef struct {
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'd2,     16'd6,     1'b0, 16'd8,     1'b0, 1'b0});
    vecs.push_back('{16'd16,    16'd23,    1'b0, 16'd39,    1'b0, 1'b0});
    vecs.push_back('{16'd124,   16'd215,   1'b0, 16'd339,   1'b0, 1'b0});
    vecs.push_back('{16'd1504,  16'd4120,  1'b0, 16'd5624,  1'b0, 1'b0});
    vecs.push_back('{16'd15031, 16'd10154, 1'b0, 16'd25185, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0});
    vecs.push_back('{16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1, 1'b0});
    vecs.push_back('{16'h0000,  16'h0000,  1'b1, 16'h0001,  1'b0, 1'b0});
    vecs.push_back('{16'h7FFF,  16'h0001,  1'b0, 16'h8000,  1'b0, 1'b1});
    vecs.push_back('{16'h8000,  16'h8000,  1'b0, 16'h0000,  1'b1, 1'b1});
    vecs.push_back('{16'h8000,  16'h7FFF,  1'b0, 16'hFFFF,  1'b0, 1'b0});
    vecs.push_back('{16'h0FFF,  16'h0001,  1'b0, 16'h1000,  1'b0, 1'b0});

    // reset with live operands: outputs clear immediately and stay cleared
    A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("rst_now");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_all("rst_hold");
    end
    in_valid = 1'b0;
    rst_n = 1'b1;

    // directed vectors back-to-back: a fresh result every cycle
    foreach (vecs[k]) begin
      step(vecs[k].a, vecs[k].b, vecs[k].ci, 1'b1, "vec");
      chk("vec.sum_const",  Sum,       vecs[k].s);
      chk("vec.cout_const", Cout,      vecs[k].co);
      chk("vec.ovf_const",  Ovf,       vecs[k].ov);
      chk("vec.valid",      out_valid, 1'b1);
    end

    // hold: result persists while in_valid is low
    step(16'd2, 16'd6, 1'b0, 1'b1, "hold_cap");
    for (int k = 0; k < 3; k++) begin
      step(16'd100, 16'd100, 1'b0, 1'b0, "hold");
      chk("hold.sum_const", Sum, 16'd8);
      chk("hold.valid0",    out_valid, 1'b0);
    end

    // mid-stream reset discards the in-flight operation
    step(16'h1234, 16'h4321, 1'b1, 1'b1, "pre_rst");
    A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("async_rst");
    #1 rst_n = 1'b1;
    step(16'h0101, 16'h0202, 1'b0, 1'b0, "post_rst_idle");
    step(16'h0101, 16'h0202, 1'b0, 1'b1, "post_rst_first");
    chk("post_rst.sum_const", Sum, 16'h0303);

    // random sweep with random Cin and in_valid
    for (int k = 0; k < 12000; k++) begin
      step(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
